chdr_stream_checker: RTL

- In-line, zero-latency monitor for one AXI-Stream CHDR link, parametrised over CHDR bus width.
- Passes every beat through unchanged and decodes each packet header and timestamp.
- Checks the header length field against the actual tlast position, and optionally checks sequence-number continuity.
- Sits between crossbar/transport ports and endpoints for debug and for on-chip self-checking in testbenches.

---
 rtl/chdr_stream_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/chdr_stream_checker.sv
// chdr_stream_checker
//   Zero-latency in-line monitor for one AXI-Stream CHDR link. Every beat is
//   passed straight through. Each packet header (and timestamp, for data
//   packets with timestamp) is decoded. The header length field is checked
//   against the real tlast position. Optionally, sequence-number continuity is
//   checked as well.
//
// Ports
//   chdr_clk, chdr_rst        clock, synchronous active-high reset
//   s_axis_* / m_axis_*       pass-through stream (tready flows upstream)
//   hdr_stb                   one-cycle pulse, decoded hdr_* fields are valid
//   hdr_pkt_type .. hdr_eob   decoded header fields, held until next hdr_stb
//   hdr_timestamp             timestamp for type 7, otherwise 0
//   err_stb, err_code         registered error pulse: 1 early tlast,
//                             2 missing tlast, 3 sequence error
//   pkt_count, err_count      saturating packet / error counters
module chdr_stream_checker #(
  parameter int CHDR_W    = 64,
  parameter int SEQ_CHECK = 1,
  parameter int CNT_W     = 32
) (
  input  logic              chdr_clk,
  input  logic              chdr_rst,
  input  logic [CHDR_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [CHDR_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              hdr_stb,
  output logic [2:0]        hdr_pkt_type,
  output logic [15:0]       hdr_seq_num,
  output logic [15:0]       hdr_length,
  output logic [15:0]       hdr_dst_epid,
  output logic [4:0]        hdr_num_mdata,
  output logic              hdr_eob,
  output logic [63:0]       hdr_timestamp,
  output logic              err_stb,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BPB      = CHDR_W / 8;
  localparam int LOG2_BPB = $clog2(BPB);
  localparam bit WIDE     = (CHDR_W > 64);
  localparam int TS_LO    = WIDE ? 64 : 0;

  typedef enum logic [1:0] {ST_HDR, ST_TS, ST_BODY, ST_DRAIN} state_t;

  state_t      r_state, w_state_nxt, w_end_state;
  logic [16:0] r_beat_cnt, r_exp_beats;
  logic [63:0] r_p_hdr;
  logic        r_seq_vld;
  logic [15:0] r_seq_last;

  logic        w_xfer;
  logic [63:0] w_hdr_src, w_ts_hdr, w_ts_new;
  logic [15:0] w_len, w_seq_exp;
  logic [16:0] w_exp_hdr, w_exp, w_beat_n;
  logic [1:0]  w_end_code, w_len_code, w_code, w_err_inc;
  logic        w_seq_err, w_hdr_lat, w_hdr_done;
  logic [CNT_W:0] w_pkt_sum, w_err_sum;
  logic        w_unused;

  assign s_axis_tready = m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid;

  assign w_xfer = s_axis_tvalid && m_axis_tready;

  // In TS the header came one beat earlier, so its fields come from the shadow copy
  assign w_hdr_src = (r_state == ST_HDR) ? s_axis_tdata[63:0] : r_p_hdr;
  assign w_len     = w_hdr_src[31:16];
  assign w_ts_hdr  = WIDE ? s_axis_tdata[TS_LO +: 64] : '0;
  assign w_ts_new  = (r_state == ST_TS) ? s_axis_tdata[63:0] :
                     ((w_hdr_src[55:53] == 3'd7) ? w_ts_hdr : '0);
  assign w_seq_exp = r_seq_last + 16'd1;
  assign w_unused  = &{1'b0, w_hdr_src[63:58], w_hdr_src[56]};

  // 17-bit ceil division keeps length 0xFFFF from wrapping to zero beats
  assign w_exp_hdr = (w_len < 16'd8) ? 17'd1 :
                     (({1'b0, w_len} + 17'(BPB - 1)) >> LOG2_BPB);
  assign w_exp     = (r_state == ST_HDR) ? w_exp_hdr : r_exp_beats;
  assign w_beat_n  = (r_state == ST_HDR) ? 17'd1 : (r_beat_cnt + 17'd1);

  // End-of-packet rule shared by HDR, TS and BODY
  always_comb begin
    w_end_state = ST_BODY;
    w_end_code  = 2'd0;
    if (s_axis_tlast) begin
      w_end_state = ST_HDR;
      if (w_beat_n < w_exp) w_end_code = 2'd1;
    end else if (w_beat_n >= w_exp) begin
      w_end_state = ST_DRAIN;
      w_end_code  = 2'd2;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_code  = 2'd0;
    w_seq_err   = 1'b0;
    w_hdr_lat   = 1'b0;
    w_hdr_done  = 1'b0;
    if (w_xfer) begin
      unique case (r_state)
        ST_HDR: begin
          w_hdr_lat = 1'b1;
          w_seq_err = (SEQ_CHECK != 0) && r_seq_vld && (w_hdr_src[47:32] != w_seq_exp);
          if (w_hdr_src[55:53] == 3'd7 && !WIDE) begin
            w_state_nxt = ST_TS;
          end else begin
            w_hdr_done  = 1'b1;
            w_state_nxt = w_end_state;
            w_len_code  = w_end_code;
          end
        end
        ST_TS, ST_BODY: begin
          w_hdr_done  = (r_state == ST_TS);
          w_state_nxt = w_end_state;
          w_len_code  = w_end_code;
        end
        ST_DRAIN: begin
          if (s_axis_tlast) w_state_nxt = ST_HDR;
        end
        default: w_state_nxt = ST_HDR;
      endcase
    end
  end

  // Length errors take priority in the code; both still count
  assign w_code    = (w_len_code != 2'd0) ? w_len_code : (w_seq_err ? 2'd3 : 2'd0);
  assign w_err_inc = {1'b0, (w_len_code != 2'd0)} + {1'b0, w_seq_err};
  assign w_pkt_sum = {1'b0, pkt_count} + (CNT_W+1)'(w_xfer && s_axis_tlast);
  assign w_err_sum = {1'b0, err_count} + (CNT_W+1)'(w_err_inc);

  always_ff @(posedge chdr_clk) begin
    if (chdr_rst) begin
      r_state       <= ST_HDR;
      r_beat_cnt    <= '0;
      r_exp_beats   <= '0;
      r_p_hdr       <= '0;
      r_seq_vld     <= 1'b0;
      r_seq_last    <= '0;
      hdr_stb       <= 1'b0;
      hdr_pkt_type  <= '0;
      hdr_seq_num   <= '0;
      hdr_length    <= '0;
      hdr_dst_epid  <= '0;
      hdr_num_mdata <= '0;
      hdr_eob       <= 1'b0;
      hdr_timestamp <= '0;
      err_stb       <= 1'b0;
      err_code      <= '0;
      pkt_count     <= '0;
      err_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && r_state != ST_DRAIN) r_beat_cnt <= w_beat_n;
      if (w_hdr_lat) begin
        r_p_hdr     <= s_axis_tdata[63:0];
        r_exp_beats <= w_exp_hdr;
        r_seq_vld   <= 1'b1;
        r_seq_last  <= s_axis_tdata[47:32];
      end
      hdr_stb <= w_hdr_done;
      if (w_hdr_done) begin
        hdr_pkt_type  <= w_hdr_src[55:53];
        hdr_seq_num   <= w_hdr_src[47:32];
        hdr_length    <= w_hdr_src[31:16];
        hdr_dst_epid  <= w_hdr_src[15:0];
        hdr_num_mdata <= w_hdr_src[52:48];
        hdr_eob       <= w_hdr_src[57];
        hdr_timestamp <= w_ts_new;
      end
      err_stb   <= (w_code != 2'd0);
      err_code  <= w_code;
      pkt_count <= w_pkt_sum[CNT_W] ? '1 : w_pkt_sum[CNT_W-1:0];
      err_count <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    end
  end

endmodule
